commit_trace_fifo: RTL
======================

Name: commit_trace_fifo

Overview:
Synthesizable commit-stage trace capture block. It sits directly upstream of the simulation trace consumer and any on-chip trace sink. Each cycle it samples up to two retiring instructions plus one exception from the commit stage and serializes them into a single record stream with a valid/ready handshake. Trace loss is never silent: overflow is counted and reported in-band with a marker record.

Parameters:
- DEPTH, 8, number of FIFO record slots; power of two, minimum 4.
- NR_COMMIT_PORTS, 2, commit ports sampled per cycle; fixed at 2 in this revision.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- trace_en_i  in  1  capture enable; when 0, no events are captured or dropped.
- commit_valid_i  in  2  per-port commit acknowledge.
- commit_pc_i  in  2xVLEN  committed PC.
- commit_instr_i  in  2x32  raw instruction word.
- commit_we_i  in  2  register write enable.
- commit_fpr_i  in  2  destination is the FP register file.
- commit_waddr_i  in  2x5  destination register.
- commit_wdata_i  in  2x64  write-back data.
- priv_lvl_i  in  2  current privilege level.
- debug_mode_i  in  1  core is in debug mode.
- exception_valid_i  in  1  exception taken this cycle.
- exception_cause_i  in  64  exception cause.
- exception_tval_i  in  64  exception tval.
- rec_o  out  trace_rec_t  head record.
- rec_valid_o  out  1  head record valid.
- rec_ready_i  in  1  consumer accepts the head record.
- drop_cnt_o  out  32  total events dropped since reset.
- full_o  out  1  FIFO occupancy equals DEPTH.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - rec_valid_o=0, full_o=0, drop_cnt_o=0.
  - Pointers and occupancy = 0, ovf_pending=0, ovf_cnt=0.
  - rec_o = all zeros.
- Events per cycle (only while trace_en_i=1):
  - Order: port0 commit, port1 commit, then exception.
  - n_ev = popcount(commit_valid_i) + exception_valid_i, range 0..3.
  - Exception events are suppressed when debug_mode_i=1 and cause is BREAKPOINT.
- Record kinds:
  - INSTR: pc, instr, we, fpr, waddr, wdata, priv, debug.
  - EXC: pc of port0, cause, tval, priv.
  - OVF: 32-bit count of events lost since the last OVF record.
- Space check:
  - free = DEPTH - occupancy at the start of the cycle.
  - A pop in the same cycle is not credited to free (conservative rule).
  - need = n_ev + (ovf_pending ? 1 : 0).
- Write rule:
  - If need <= free: write all records atomically, OVF first when pending, then clear ovf_pending and ovf_cnt.
  - Else: write nothing. drop_cnt_o += n_ev (saturating at 2^32-1), ovf_cnt += n_ev (saturating), ovf_pending=1.
  - Events are never partially written.
- Latency: records written in cycle T are visible on rec_o in cycle T+1 (first-word-fall-through from a registered array).
- Output handshake:
  - rec_valid_o = (occupancy != 0).
  - Pop on rec_valid_o & rec_ready_i.
  - rec_o stays stable while rec_valid_o=1 and rec_ready_i=0.
- Pointers: wrap modulo DEPTH. Occupancy update per cycle is +writes - pop.
- full_o: registered, equals (occupancy == DEPTH).
- trace_en_i deasserted:
  - Already-queued records still drain.
  - ovf_pending is retained.

Optional Feature:
- Macro: COMMIT_TRACE_TIMESTAMP_EN.
- Defined:
  - A 64-bit free-running cycle counter runs, reset to 0 and incrementing every cycle after reset.
  - trace_rec_t gains a timestamp field holding the counter value at capture.
  - All records written in the same cycle carry the same timestamp.
- Undefined: no counter and no timestamp field. Record width shrinks accordingly.

Decomposition:
- Shared package commit_trace_pkg:
  - trace_kind_e {INSTR, EXC, OVF}.
  - trace_rec_t packed struct; timestamp field guarded by COMMIT_TRACE_TIMESTAMP_EN.
  - Constant MAX_EV_PER_CYCLE=3.
- One sub-module: trace_mwfifo.
  - Up to 3 writes and 1 read per cycle; DEPTH-entry register array.
  - Outputs occupancy and free count.
- The top level holds event packing, the space check, and the overflow/drop logic.

Test Plan:
- Port0 commit, pc=0x8000_0000, instr=0x00500093, we=1, waddr=1, wdata=5, rec_ready_i=1 -> next cycle one INSTR record with exactly these fields and rec_valid_o=1 for one cycle.
- Both ports commit plus a non-debug exception (cause=2, tval=0xdead) in one cycle -> three records in order INSTR(p0), INSTR(p1), EXC; occupancy=3.
- DEPTH=4, rec_ready_i=0, two dual-commit cycles, then one single commit -> full_o=1, drop_cnt_o=1. Drain all 4, then one commit -> OVF(count=1) followed by INSTR; drop_cnt_o stays 1.
- Full FIFO with rec_ready_i=1 and 1 new commit in the same cycle -> commit dropped (no pop credit), drop_cnt_o increments by 1, occupancy becomes 3.
- Exception with debug_mode_i=1 and cause=BREAKPOINT -> no record written, drop_cnt_o unchanged.
- Assert rst_i asynchronously with 3 entries queued -> rec_valid_o=0 and drop_cnt_o=0 before the next clock edge. After release, the first commit yields a correct INSTR record. With COMMIT_TRACE_TIMESTAMP_EN, that record carries the timestamp equal to cycles since reset.

Source files
------------

// File: rtl/commit_trace_pkg.sv
// Shared types and constants for the commit-stage trace capture block.
// Optional build macro: COMMIT_TRACE_TIMESTAMP_EN adds a 64-bit capture
// timestamp to every trace record.
package commit_trace_pkg;

    localparam int VLEN             = 64;
    localparam int COMMIT_PORTS     = 2;
    localparam int MAX_EV_PER_CYCLE = 3;
    // A pending overflow marker plus a full set of events must land atomically.
    localparam int MAX_WR_PER_CYCLE = MAX_EV_PER_CYCLE + 1;
    localparam logic [63:0] CAUSE_BREAKPOINT = 64'd3;

    typedef enum logic [1:0] {
        INSTR = 2'd0,
        EXC   = 2'd1,
        OVF   = 2'd2
    } trace_kind_e;

    // Fields not meaningful for a given kind are held at zero.
    typedef struct packed {
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        logic [63:0]     timestamp;
`endif
        trace_kind_e     kind;
        logic [VLEN-1:0] pc;
        logic [31:0]     instr;
        logic            we;
        logic            fpr;
        logic [4:0]      waddr;
        logic [63:0]     wdata;
        logic [1:0]      priv;
        logic            debug;
        logic [63:0]     cause;
        logic [63:0]     tval;
        logic [31:0]     ovf_cnt;
    } trace_rec_t;

    // 32-bit counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hffff_ffff : sum[31:0];
    endfunction

endpackage

// File: rtl/commit_trace_fifo_if.sv
// Commit-side sampling bus plus the record output stream of the trace block.
// master: commit stage / trace consumer side; slave: the trace capture block.
interface commit_trace_fifo_if;
    import commit_trace_pkg::*;

    logic                                   trace_en_i;
    logic [COMMIT_PORTS-1:0]                commit_valid_i;
    logic [COMMIT_PORTS-1:0][VLEN-1:0]      commit_pc_i;
    logic [COMMIT_PORTS-1:0][31:0]          commit_instr_i;
    logic [COMMIT_PORTS-1:0]                commit_we_i;
    logic [COMMIT_PORTS-1:0]                commit_fpr_i;
    logic [COMMIT_PORTS-1:0][4:0]           commit_waddr_i;
    logic [COMMIT_PORTS-1:0][63:0]          commit_wdata_i;
    logic [1:0]                             priv_lvl_i;
    logic                                   debug_mode_i;
    logic                                   exception_valid_i;
    logic [63:0]                            exception_cause_i;
    logic [63:0]                            exception_tval_i;
    trace_rec_t                             rec_o;
    logic                                   rec_valid_o;
    logic                                   rec_ready_i;
    logic [31:0]                            drop_cnt_o;
    logic                                   full_o;

    modport master (
        output trace_en_i, commit_valid_i, commit_pc_i, commit_instr_i, commit_we_i,
               commit_fpr_i, commit_waddr_i, commit_wdata_i, priv_lvl_i, debug_mode_i,
               exception_valid_i, exception_cause_i, exception_tval_i, rec_ready_i,
        input  rec_o, rec_valid_o, drop_cnt_o, full_o
    );

    modport slave (
        input  trace_en_i, commit_valid_i, commit_pc_i, commit_instr_i, commit_we_i,
               commit_fpr_i, commit_waddr_i, commit_wdata_i, priv_lvl_i, debug_mode_i,
               exception_valid_i, exception_cause_i, exception_tval_i, rec_ready_i,
        output rec_o, rec_valid_o, drop_cnt_o, full_o
    );

endinterface

// File: rtl/trace_mwfifo.sv
// Multi-write, single-read record FIFO. Up to MAX_WR_PER_CYCLE records are
// written contiguously per cycle; the head is presented first-word-fall-through
// from the register array and reads as zero while empty.
module trace_mwfifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       wr_cnt,
    input  trace_rec_t       wr_data [MAX_WR_PER_CYCLE],
    input  logic             rd_en,
    output trace_rec_t       rd_data,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] free_cnt,
    output logic             full
);

    trace_rec_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] occ_reg;
    logic [CNT_W-1:0] occ_next;
    logic             full_reg;
    logic [PTR_W-1:0] slot_addr [MAX_WR_PER_CYCLE];

    // Consecutive slots from the write pointer; power-of-two depth wraps for free.
    for (genvar gi = 0; gi < MAX_WR_PER_CYCLE; gi++) begin : g_slot
        assign slot_addr[gi] = wr_ptr_reg + PTR_W'(gi);
    end

    assign occ_next  = occ_reg + CNT_W'(wr_cnt) - CNT_W'(rd_en);
    assign occupancy = occ_reg;
    assign free_cnt  = CNT_W'(DEPTH) - occ_reg;
    assign full      = full_reg;
    assign rd_data   = (occ_reg != '0) ? mem[rd_ptr_reg] : '0;

    // Record storage: write the first wr_cnt slots.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_WR_PER_CYCLE; i++) begin
            if (i < int'(wr_cnt)) begin
                mem[slot_addr[i]] <= wr_data[i];
            end
        end
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            full_reg   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(wr_cnt);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(rd_en);
            occ_reg    <= occ_next;
            full_reg   <= (occ_next == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit-stage trace capture: samples two commit ports and one exception per
// cycle, packs them into records and queues them atomically. When the queue
// cannot take a whole cycle's events they are dropped, counted, and later
// reported in-band with an OVF marker record ahead of the next accepted events.
// Optional build macro: COMMIT_TRACE_TIMESTAMP_EN stamps every record with a
// free-running cycle count taken at capture.
module commit_trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int NR_COMMIT_PORTS = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    commit_trace_fifo_if.slave cif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NR_COMMIT_PORTS-1:0] port_ev;
    logic                       exc_ev;
    logic [1:0]                 n_ev;
    logic [2:0]                 need;
    logic                       fits;
    logic                       do_write;
    logic                       do_drop;
    logic [2:0]                 wr_cnt;
    logic [1:0]                 slot;
    trace_rec_t                 ev_rec [MAX_WR_PER_CYCLE];
    trace_rec_t                 head_rec;
    logic [CNT_W-1:0]           occupancy;
    logic [CNT_W-1:0]           free_cnt;
    logic                       fifo_full;
    logic                       pop;
    logic                       ovf_pending_reg;
    logic [31:0]                ovf_cnt_reg;
    logic [31:0]                drop_cnt_reg;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [63:0] ts_reg;

    // Free-running cycle counter used as the capture timestamp.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 64'd1;
        end
    end
`endif

    for (genvar gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_port_ev
        assign port_ev[gi] = cif.trace_en_i & cif.commit_valid_i[gi];
    end

    // A breakpoint taken while already in debug mode is debugger traffic, not trace.
    assign exc_ev = cif.trace_en_i & cif.exception_valid_i &
                    ~(cif.debug_mode_i & (cif.exception_cause_i == CAUSE_BREAKPOINT));

    // Event count for this cycle.
    always_comb begin
        n_ev = 2'(exc_ev);
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            n_ev = n_ev + 2'(port_ev[p]);
        end
    end

    // Space check against occupancy at cycle start; a same-cycle pop earns no credit.
    assign need     = {1'b0, n_ev} + 3'(ovf_pending_reg);
    assign fits     = CNT_W'(need) <= free_cnt;
    assign do_write = (n_ev != 2'd0) && fits;
    assign do_drop  = (n_ev != 2'd0) && !fits;
    assign wr_cnt   = do_write ? need : 3'd0;

    // Pack records in order: pending OVF marker, port0, port1, exception.
    always_comb begin
        for (int i = 0; i < MAX_WR_PER_CYCLE; i++) begin
            ev_rec[i] = '0;
        end
        slot = 2'd0;
        if (ovf_pending_reg) begin
            ev_rec[slot].kind    = OVF;
            ev_rec[slot].ovf_cnt = ovf_cnt_reg;
            slot = slot + 2'd1;
        end
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (port_ev[p]) begin
                ev_rec[slot].kind  = INSTR;
                ev_rec[slot].pc    = cif.commit_pc_i[p];
                ev_rec[slot].instr = cif.commit_instr_i[p];
                ev_rec[slot].we    = cif.commit_we_i[p];
                ev_rec[slot].fpr   = cif.commit_fpr_i[p];
                ev_rec[slot].waddr = cif.commit_waddr_i[p];
                ev_rec[slot].wdata = cif.commit_wdata_i[p];
                ev_rec[slot].priv  = cif.priv_lvl_i;
                ev_rec[slot].debug = cif.debug_mode_i;
                slot = slot + 2'd1;
            end
        end
        if (exc_ev) begin
            ev_rec[slot].kind  = EXC;
            ev_rec[slot].pc    = cif.commit_pc_i[0];
            ev_rec[slot].cause = cif.exception_cause_i;
            ev_rec[slot].tval  = cif.exception_tval_i;
            ev_rec[slot].priv  = cif.priv_lvl_i;
        end
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        for (int i = 0; i < MAX_WR_PER_CYCLE; i++) begin
            ev_rec[i].timestamp = ts_reg;
        end
`endif
    end

    // Overflow bookkeeping: a successful write flushes the marker, a drop arms it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_pending_reg <= 1'b0;
            ovf_cnt_reg     <= '0;
            drop_cnt_reg    <= '0;
        end else if (do_write) begin
            ovf_pending_reg <= 1'b0;
            ovf_cnt_reg     <= '0;
        end else if (do_drop) begin
            ovf_pending_reg <= 1'b1;
            ovf_cnt_reg     <= sat_add32(ovf_cnt_reg, n_ev);
            drop_cnt_reg    <= sat_add32(drop_cnt_reg, n_ev);
        end
    end

    assign pop = (occupancy != '0) & cif.rec_ready_i;

    trace_mwfifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .wr_cnt    (wr_cnt),
        .wr_data   (ev_rec),
        .rd_en     (pop),
        .rd_data   (head_rec),
        .occupancy (occupancy),
        .free_cnt  (free_cnt),
        .full      (fifo_full)
    );

    assign cif.rec_o       = head_rec;
    assign cif.rec_valid_o = (occupancy != '0);
    assign cif.drop_cnt_o  = drop_cnt_reg;
    assign cif.full_o      = fifo_full;

endmodule
